// File: rtl/input_port_reader.sv
`default_nettype none
// ============================================================================
//  Module      : input_port_reader
//  Description : Consumer side of a router input buffer. Pops 16-bit flits
//                (one-cycle read latency), XY-routes the head flit, requests
//                the output port from the switch allocator and streams the
//                packet to the crossbar over valid/ready, releasing the port
//                after the tail flit.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_port_reader #(
    parameter int X_ID = 0,
    parameter int Y_ID = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        buf_empty_i,
    output logic        buf_read_o,
    input  logic        buf_valid_i,
    input  logic [15:0] buf_data_i,
    output logic        req_o,
    output logic [4:0]  req_port_o,
    input  logic        grant_i,
    output logic        out_valid_o,
    output logic [15:0] out_data_o,
    input  logic        out_ready_i,
    output logic        release_o,
    output logic        drop_o
);

    localparam logic [1:0] c_x_id       = 2'(X_ID);
    localparam logic [1:0] c_y_id       = 2'(Y_ID);
    localparam logic [4:0] c_PORT_LOCAL = 5'b00001;
    localparam logic [4:0] c_PORT_NORTH = 5'b00010;
    localparam logic [4:0] c_PORT_EAST  = 5'b00100;
    localparam logic [4:0] c_PORT_SOUTH = 5'b01000;
    localparam logic [4:0] c_PORT_WEST  = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  req_port_q;
    logic        tail_seen_q;
    logic        inflight_q;

    // Two-entry skid queue
    logic [15:0] qdata_q [2];
    logic [15:0] qdata_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q,  count_d;

    logic [15:0] w_q_head;
    logic        w_arr_head;
    logic        w_arr_last;
    logic        w_enq;
    logic        w_fwd_valid;
    logic        w_xfer;
    logic        w_release;
    logic        w_drop;
    logic        w_read;
    logic [2:0]  w_occ;
    logic [4:0]  w_route;

    // Type bit 14 marks a head (01/11); bit 15 marks a packet end (10/11)
    assign w_arr_head  = buf_valid_i &  buf_data_i[14];
    assign w_arr_last  = buf_valid_i &  buf_data_i[15];
    assign w_q_head    = qdata_q[rd_ptr_q];
    assign w_fwd_valid = (state_q == ST_FWD) && (count_q != 2'd0);
    assign w_xfer      = w_fwd_valid & out_ready_i;
    assign w_release   = w_xfer & w_q_head[15];
    assign w_drop      = (state_q == ST_IDLE) & buf_valid_i & ~buf_data_i[14];
    // In IDLE only a head may enter; stray body/tail flits are discarded
    assign w_enq       = buf_valid_i & ((state_q != ST_IDLE) | buf_data_i[14]);
    // Occupancy plus in-flight read, with a same-cycle transfer freeing a slot
    assign w_occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, w_xfer};

    // XY routing: X dimension resolved first, then Y, else local delivery
    always_comb begin
        w_route = c_PORT_LOCAL;
        if (buf_data_i[13:12] > c_x_id) begin
            w_route = c_PORT_EAST;
        end else if (buf_data_i[13:12] < c_x_id) begin
            w_route = c_PORT_WEST;
        end else if (buf_data_i[11:10] > c_y_id) begin
            w_route = c_PORT_NORTH;
        end else if (buf_data_i[11:10] < c_y_id) begin
            w_route = c_PORT_SOUTH;
        end
    end

    // Read gating: one outstanding head in IDLE, bounded prefetch otherwise
    always_comb begin
        w_read = 1'b0;
        if (state_q == ST_IDLE) begin
            w_read = !buf_empty_i && (count_q == 2'd0) && !inflight_q;
        end else begin
            w_read = !buf_empty_i && !tail_seen_q && (w_occ < 3'd2) && !w_arr_last;
        end
    end

    // Queue next-state: write at wr_ptr, pop at rd_ptr on a crossbar transfer
    always_comb begin
        qdata_d  = qdata_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_enq) begin
            qdata_d[wr_ptr_q] = buf_data_i;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (w_xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, w_enq} - {1'b0, w_xfer};
    end

    // Queue storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qdata_q[0] <= '0;
            qdata_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            qdata_q    <= qdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // In-flight marker: data returns exactly one cycle after the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= buf_read_o;
        end
    end

    // Packet state machine with latched route and tail tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_port_q  <= 5'b00000;
            tail_seen_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_arr_head) begin
                        state_q     <= ST_REQ;
                        req_port_q  <= w_route;
                        tail_seen_q <= buf_data_i[15];
                    end
                end
                ST_REQ: begin
                    if (w_arr_last) begin
                        tail_seen_q <= 1'b1;
                    end
                    if (grant_i) begin
                        state_q <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (w_release) begin
                        state_q     <= ST_IDLE;
                        req_port_q  <= 5'b00000;
                        tail_seen_q <= 1'b0;
                    end else if (w_arr_last) begin
                        tail_seen_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Input-dependent outputs are forced low while reset is held
    assign buf_read_o  = w_read & reset;
    assign drop_o      = w_drop & reset;
    assign req_o       = (state_q == ST_REQ);
    assign req_port_o  = req_port_q;
    assign out_valid_o = w_fwd_valid;
    assign out_data_o  = w_fwd_valid ? w_q_head : 16'h0000;
    assign release_o   = w_release;

endmodule
`default_nettype wire

// File: tb/tb_input_port_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_port_reader
//  Description : Directed self-checking bench for input_port_reader
//                (X_ID=1, Y_ID=1) with a buffer model and auto-grant model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_port_reader;

    localparam int GNT_DLY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        buf_empty_i;
    logic        buf_read_o;
    logic        buf_valid_i;
    logic [15:0] buf_data_i;
    logic        req_o;
    logic [4:0]  req_port_o;
    logic        grant_i;
    logic        out_valid_o;
    logic [15:0] out_data_o;
    logic        out_ready_i;
    logic        release_o;
    logic        drop_o;

    always #5 clk = ~clk;

    input_port_reader #(.X_ID(1), .Y_ID(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .buf_empty_i (buf_empty_i),
        .buf_read_o  (buf_read_o),
        .buf_valid_i (buf_valid_i),
        .buf_data_i  (buf_data_i),
        .req_o       (req_o),
        .req_port_o  (req_port_o),
        .grant_i     (grant_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .release_o   (release_o),
        .drop_o      (drop_o)
    );

    // Buffer model storage
    logic [15:0] mem [0:255];
    int          mem_wr = 0;
    int          mem_rd = 0;
    assign buf_empty_i = (mem_rd == mem_wr);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int max_out  = 0;
    logic req_prev = 1'b0;
    logic gnt_prev = 1'b0;
    logic val_prev = 1'b0;

    int          read_cyc[$];
    int          xfer_cyc[$];
    logic [15:0] xfer_dat[$];
    int          rel_cyc[$];
    logic [15:0] rel_dat[$];
    logic [4:0]  rel_port[$];
    int          drop_cyc[$];
    int          req_rise_cyc[$];
    logic [4:0]  req_rise_port[$];
    int          gnt_rise_cyc[$];
    int          val_rise_cyc[$];
    logic        val_rise_req[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[mem_wr % 256] = d;
        mem_wr++;
    endtask

    task automatic clear_logs();
        read_cyc.delete();     xfer_cyc.delete();  xfer_dat.delete();
        rel_cyc.delete();      rel_dat.delete();   rel_port.delete();
        drop_cyc.delete();     req_rise_cyc.delete(); req_rise_port.delete();
        gnt_rise_cyc.delete(); val_rise_cyc.delete(); val_rise_req.delete();
        max_out = 0;
    endtask

    // One clock cycle: sample outputs mid-cycle, then drive buffer/grant after the edge
    task automatic step();
        logic rd_s;
        logic g;
        int   outstanding;
        @(negedge clk);
        cyc++;
        rd_s = buf_read_o;
        g    = grant_i;
        if (buf_read_o) read_cyc.push_back(cyc);
        if (out_valid_o && out_ready_i) begin
            xfer_cyc.push_back(cyc);
            xfer_dat.push_back(out_data_o);
        end
        if (release_o) begin
            rel_cyc.push_back(cyc);
            rel_dat.push_back(out_data_o);
            rel_port.push_back(req_port_o);
        end
        if (drop_o) drop_cyc.push_back(cyc);
        if (req_o && !req_prev) begin
            req_rise_cyc.push_back(cyc);
            req_rise_port.push_back(req_port_o);
        end
        if (grant_i && !gnt_prev) gnt_rise_cyc.push_back(cyc);
        if (out_valid_o && !val_prev) begin
            val_rise_cyc.push_back(cyc);
            val_rise_req.push_back(req_o);
        end
        req_prev = req_o;
        gnt_prev = grant_i;
        val_prev = out_valid_o;
        outstanding = read_cyc.size() - xfer_cyc.size() - drop_cyc.size();
        if (outstanding > max_out) max_out = outstanding;
        if (release_o || !reset) begin
            g       = 1'b0;
            req_cnt = 0;
        end else if (req_o) begin
            req_cnt++;
            if (req_cnt >= GNT_DLY) g = 1'b1;
        end
        @(posedge clk);
        #1;
        grant_i = g;
        if (!reset) begin
            mem_rd      = mem_wr;
            buf_valid_i = 1'b0;
            buf_data_i  = 16'h0000;
        end else if (rd_s && (mem_rd != mem_wr)) begin
            buf_data_i  = mem[mem_rd % 256];
            buf_valid_i = 1'b1;
            mem_rd++;
        end else begin
            buf_valid_i = 1'b0;
            buf_data_i  = 16'h0000;
        end
    endtask

    task automatic run_until(input int n_rel, input int budget, input string tag);
        int k;
        k = 0;
        while ((rel_cyc.size() < n_rel) && (k < budget)) begin
            step();
            k++;
        end
        check_eq(tag, 32'(rel_cyc.size() >= n_rel), 32'd1);
    endtask

    function automatic int reads_in(input int lo, input int hi);
        int n;
        n = 0;
        foreach (read_cyc[i]) if (read_cyc[i] >= lo && read_cyc[i] <= hi) n++;
        return n;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({buf_read_o, req_o, req_port_o, out_valid_o, out_data_o, release_o, drop_o});
    endfunction

    logic [15:0] rt_flit [5] = '{16'hF000, 16'hCC00, 16'hD800, 16'hD000, 16'hD400};
    logic [4:0]  rt_port [5] = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};
    logic [15:0] t3_exp  [4] = '{16'h5000, 16'h0111, 16'h0222, 16'h8333};

    initial begin
        int k;
        int s0;
        reset       = 1'b0;
        grant_i     = 1'b0;
        out_ready_i = 1'b1;
        buf_valid_i = 1'b0;
        buf_data_i  = 16'h0000;

        // Reset state with a non-empty buffer
        step();
        step();
        push(16'h6400);
        #1;
        check_eq("reset_outs", all_outs(), 32'd0);

        // T1: three-flit packet routed EAST
        push(16'h1234);
        push(16'h8ABC);
        reset = 1'b1;
        clear_logs();
        run_until(1, 40, "t1_done");
        check_eq("t1_nxfer", xfer_cyc.size(), 3);
        check_eq("t1_port", 32'(req_rise_port[0]), 32'b00100);
        check_eq("t1_req_lat", req_rise_cyc[0] - read_cyc[0], 2);
        check_eq("t1_d0", 32'(xfer_dat[0]), 32'h6400);
        check_eq("t1_d1", 32'(xfer_dat[1]), 32'h1234);
        check_eq("t1_d2", 32'(xfer_dat[2]), 32'h8ABC);
        check_eq("t1_consec", xfer_cyc[2] - xfer_cyc[0], 2);
        check_eq("t1_rel_dat", 32'(rel_dat[0]), 32'h8ABC);
        check_eq("t1_rel_cyc", rel_cyc[0], xfer_cyc[2]);
        check_eq("t1_gnt_to_valid", val_rise_cyc[0] - gnt_rise_cyc[0], 1);
        check_eq("t1_req_dropped", 32'(val_rise_req[0]), 32'd0);
        check_eq("t1_rel_port", 32'(rel_port[0]), 32'b00100);
        check_eq("t1_idle_port", 32'({req_o, req_port_o}), 32'd0);

        // T2: back-to-back single-flit packets, WEST then LOCAL
        clear_logs();
        push(16'hC500);
        push(16'hD400);
        run_until(2, 60, "t2_done");
        check_eq("t2_nxfer", xfer_cyc.size(), 2);
        check_eq("t2_portA", 32'(rel_port[0]), 32'b10000);
        check_eq("t2_portB", 32'(rel_port[1]), 32'b00001);
        check_eq("t2_rel_same", rel_cyc[0], xfer_cyc[0]);
        check_eq("t2_reads_pre_rel", reads_in(0, rel_cyc[0]), 1);
        check_eq("t2_B_read", read_cyc[1] - rel_cyc[0], 1);
        check_eq("t2_B_req", req_rise_cyc[1] - rel_cyc[0], 3);

        // T3: four-flit packet with a five-cycle crossbar stall
        clear_logs();
        push(t3_exp[0]);
        push(t3_exp[1]);
        push(t3_exp[2]);
        push(t3_exp[3]);
        k = 0;
        while ((xfer_cyc.size() < 1) && (k < 30)) begin
            step();
            k++;
        end
        check_eq("t3_first_xfer", 32'(xfer_cyc.size() >= 1), 32'd1);
        out_ready_i = 1'b0;
        s0 = cyc + 1;
        repeat (5) step();
        out_ready_i = 1'b1;
        run_until(1, 40, "t3_done");
        check_eq("t3_stall_reads", reads_in(s0, s0 + 4), 0);
        check_eq("t3_max_held", max_out, 2);
        check_eq("t3_nxfer", xfer_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_d%0d", i), 32'(xfer_dat[i]), 32'(t3_exp[i]));
        end

        // T4: stray body dropped in IDLE, then a NORTH head
        clear_logs();
        push(16'h1234);
        push(16'hD800);
        run_until(1, 40, "t4_done");
        check_eq("t4_ndrop", drop_cyc.size(), 1);
        check_eq("t4_drop_cyc", drop_cyc[0] - read_cyc[0], 1);
        check_eq("t4_req_after_drop", req_rise_cyc[0] - drop_cyc[0], 3);
        check_eq("t4_port", 32'(req_rise_port[0]), 32'b00010);
        check_eq("t4_nxfer", xfer_cyc.size(), 1);
        check_eq("t4_d0", 32'(xfer_dat[0]), 32'hD800);

        // Route table: X priority, both Y directions and local
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            push(rt_flit[i]);
            run_until(1, 30, $sformatf("rt%0d_done", i));
            check_eq($sformatf("rt%0d_port", i), 32'(rel_port[0]), 32'(rt_port[i]));
            check_eq($sformatf("rt%0d_dat", i), 32'(rel_dat[0]), 32'(rt_flit[i]));
        end

        // T6: reset mid-FORWARD with two flits queued
        clear_logs();
        out_ready_i = 1'b0;
        push(16'h7000);
        push(16'h0AAA);
        push(16'h0BBB);
        push(16'h8CCC);
        k = 0;
        while ((val_rise_cyc.size() < 1) && (k < 30)) begin
            step();
            k++;
        end
        step();
        step();
        check_eq("t6_pre_valid", 32'({out_valid_o, out_data_o}), 32'h17000);
        reset = 1'b0;
        #1;
        check_eq("t6_reset_now", all_outs(), 32'd0);
        step();
        step();
        check_eq("t6_reset_hold", all_outs(), 32'd0);
        reset       = 1'b1;
        out_ready_i = 1'b1;
        clear_logs();
        push(16'hD000);
        run_until(1, 30, "t6_done");
        check_eq("t6_nxfer", xfer_cyc.size(), 1);
        check_eq("t6_d0", 32'(xfer_dat[0]), 32'hD000);
        check_eq("t6_ndrop", drop_cyc.size(), 0);
        check_eq("t6_port", 32'(rel_port[0]), 32'b01000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
